// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte handshakes and the transmitter valid/ready pair shared by the UART arbiter
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 3);
  logic [NUM_REQ-1:0] req_valid, req_last, req_ready, grant, abort;
  logic [8*NUM_REQ-1:0] req_data;
  logic busy, tx_valid, tx_ready;
  logic [7:0] tx_data;
  modport master (input req_valid, req_data, req_last, tx_ready,
                  output req_ready, grant, abort, busy, tx_data, tx_valid);
  modport slave (output req_valid, req_data, req_last, tx_ready,
                 input req_ready, grant, abort, busy, tx_data, tx_valid);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART transmitter with a starvation hold timeout
module uart_tx_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int HOLD_TIMEOUT = 24000
) (
  input logic clk48,
  input logic boot_reset,
  uart_tx_arbiter_if.master bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = HOLD_TIMEOUT > 0 ? $clog2(HOLD_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLIM = TW'(HOLD_TIMEOUT > 0 ? HOLD_TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT_RDY, S_WAIT_ACK} state_t;
  state_t state, state_n;
  logic [PW-1:0] ptr, ptr_n, gi, gi_n, pick, cand;
  logic [TW-1:0] tcnt, tcnt_n;
  logic last_r, last_n, any_req, own_v, tmo, valid_n;
  logic [NUM_REQ-1:0] grant_n, ready_n, abort_n;
  logic [7:0] data_n;
  assign own_v = bus.req_valid[gi];
  // tcnt holds the starved cycles already seen, so the limit is checked one below HOLD_TIMEOUT
  assign tmo = (HOLD_TIMEOUT != 0) && (tcnt == TLIM);
  always_comb begin
    pick = ptr;
    cand = ptr;
    any_req = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = PW'((int'(ptr) + k) % NUM_REQ);
      if (bus.req_valid[cand]) begin
        pick = cand;
        any_req = 1'b1;
      end
    end
  end
  always_ff @(posedge clk48)
    if (boot_reset) begin
      state <= S_IDLE;
      ptr <= PW'(NUM_REQ - 1);
      gi <= '0;
      last_r <= 1'b0;
      tcnt <= '0;
      bus.grant <= '0;
      bus.req_ready <= '0;
      bus.abort <= '0;
      bus.busy <= 1'b0;
      bus.tx_data <= '0;
      bus.tx_valid <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      gi <= gi_n;
      last_r <= last_n;
      tcnt <= tcnt_n;
      bus.grant <= grant_n;
      bus.req_ready <= ready_n;
      bus.abort <= abort_n;
      bus.busy <= state_n != S_IDLE;
      bus.tx_data <= data_n;
      bus.tx_valid <= valid_n;
    end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (any_req) state_n = S_GRANT;
      S_GRANT: state_n = own_v ? S_WAIT_RDY : tmo ? S_IDLE : S_GRANT;
      S_WAIT_RDY: if (bus.tx_ready && !bus.tx_valid) state_n = S_WAIT_ACK;
      S_WAIT_ACK: if (!bus.tx_ready) state_n = last_r ? S_IDLE : S_GRANT;
      default: state_n = S_IDLE;
    endcase
  end
  always_comb begin
    ptr_n = ptr;
    gi_n = gi;
    last_n = last_r;
    tcnt_n = tcnt;
    grant_n = bus.grant;
    ready_n = '0;
    abort_n = '0;
    data_n = bus.tx_data;
    valid_n = bus.tx_valid;
    case (state)
      S_IDLE:
        if (any_req) begin
          gi_n = pick;
          grant_n = NUM_REQ'(1) << pick;
          tcnt_n = '0;
        end
      S_GRANT:
        if (own_v) begin
          data_n = bus.req_data[8*gi +: 8];
          last_n = bus.req_last[gi];
          ready_n = NUM_REQ'(1) << gi;
          tcnt_n = '0;
        end else if (tmo) begin
          abort_n = NUM_REQ'(1) << gi;
          grant_n = '0;
          ptr_n = gi;
        end else
          tcnt_n = tcnt + 1'b1;
      S_WAIT_RDY: if (bus.tx_ready && !bus.tx_valid) valid_n = 1'b1;
      S_WAIT_ACK:
        if (!bus.tx_ready) begin
          valid_n = 1'b0;
          if (last_r) begin
            grant_n = '0;
            ptr_n = gi;
          end
        end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a packet-level round-robin model
module tb_uart_tx_arbiter;
  localparam int N = 3;
  logic clk48 = 1'b0;
  logic boot_reset = 1'b1;
  uart_tx_arbiter_if #(.NUM_REQ(N)) bus();
  uart_tx_arbiter #(.NUM_REQ(N), .HOLD_TIMEOUT(8)) dut (.clk48(clk48), .boot_reset(boot_reset), .bus(bus));
  always #5 clk48 = ~clk48;

  logic [8:0] mem [N][64];
  int hd[N], tl[N], rr_cnt[N];
  bit en[N];
  logic [7:0] obs_data[256];
  logic [N-1:0] obs_gnt[256];
  int obs_cnt;
  logic [7:0] exp_data[256];
  int exp_req[256];
  int exp_n;
  bit tx_auto, tx_rand;
  int acc, rdy, dcnt, abort_cnt;
  int n_chk, n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (en[i] && hd[i] < tl[i]) begin
        bus.req_valid[i] = 1'b1;
        bus.req_data[8*i +: 8] = mem[i][hd[i]][7:0];
        bus.req_last[i] = mem[i][hd[i]][8];
      end else begin
        bus.req_valid[i] = 1'b0;
        bus.req_data[8*i +: 8] = 8'h00;
        bus.req_last[i] = 1'b0;
      end
    end
  endtask

  // one clock: requesters advance on req_ready, the transmitter model accepts after acc cycles, re-arms after rdy
  task automatic tick();
    @(posedge clk48);
    #1;
    for (int i = 0; i < N; i++)
      if (bus.req_ready[i] === 1'b1) begin
        hd[i]++;
        rr_cnt[i]++;
      end
    if (bus.abort !== '0 && bus.abort !== 'x) abort_cnt++;
    if (tx_auto) begin
      if (bus.tx_ready && bus.tx_valid === 1'b1) begin
        if (dcnt >= acc) begin
          bus.tx_ready = 1'b0;
          dcnt = 0;
          if (obs_cnt < 256) begin
            obs_data[obs_cnt] = bus.tx_data;
            obs_gnt[obs_cnt] = bus.grant;
          end
          obs_cnt++;
        end else dcnt++;
      end else if (!bus.tx_ready && bus.tx_valid === 1'b0) begin
        if (dcnt >= rdy) begin
          bus.tx_ready = 1'b1;
          dcnt = 0;
          if (tx_rand) begin
            acc = $urandom_range(3, 0);
            rdy = $urandom_range(3, 0);
          end
        end else dcnt++;
      end
    end
    drive();
  endtask

  task automatic push(input int r, input logic [7:0] d, input bit last);
    mem[r][tl[r]] = {last, d};
    tl[r]++;
  endtask

  task automatic do_reset();
    boot_reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
      rr_cnt[i] = 0;
      en[i] = 1'b1;
    end
    obs_cnt = 0;
    abort_cnt = 0;
    dcnt = 0;
    bus.tx_ready = 1'b1;
    drive();
    tick();
    tick();
    boot_reset = 1'b0;
  endtask

  // whole packets served in turn, starting after requester N-1, skipping requesters with nothing queued
  task automatic build_expected();
    int h[N];
    int p, i;
    bit found, last;
    p = N - 1;
    i = 0;
    exp_n = 0;
    for (int r = 0; r < N; r++) h[r] = hd[r];
    for (int pk = 0; pk < 64; pk++) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++)
        if (!found && h[(p + k) % N] < tl[(p + k) % N]) begin
          i = (p + k) % N;
          found = 1'b1;
        end
      if (!found) break;
      do begin
        exp_data[exp_n] = mem[i][h[i]][7:0];
        exp_req[exp_n] = i;
        last = mem[i][h[i]][8];
        exp_n++;
        h[i]++;
      end while (!last && h[i] < tl[i]);
      p = i;
    end
  endtask

  task automatic run_stream(input string tag, input int bound);
    int cyc = 0;
    while (obs_cnt < exp_n && cyc < bound) begin
      tick();
      cyc++;
    end
    check({tag, "_len"}, obs_cnt, exp_n);
    for (int k = 0; k < exp_n; k++) begin
      check($sformatf("%s_data%0d", tag, k), obs_data[k], exp_data[k]);
      check($sformatf("%s_grant%0d", tag, k), obs_gnt[k], 32'(1) << exp_req[k]);
    end
  endtask

  task automatic wait_obs(input int n, input int bound);
    int cyc = 0;
    while (obs_cnt < n && cyc < bound) begin
      tick();
      cyc++;
    end
    check($sformatf("wait_obs%0d", n), obs_cnt >= n, 1);
  endtask

  initial begin
    bit saw_valid;
    int g;
    n_chk = 0;
    n_pass = 0;
    tx_auto = 1'b0;
    tx_rand = 1'b0;
    acc = 2;
    rdy = 1;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.tx_ready = 1'b1;
    do_reset();
    check("rst_grant", bus.grant, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_abort", bus.abort, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", bus.tx_data, 0);

    tx_auto = 1'b1;
    push(0, 8'h4F, 0);
    push(0, 8'h0D, 0);
    push(0, 8'h0A, 1);
    drive();
    build_expected();
    run_stream("single", 200);
    check("single_ready_pulses", rr_cnt[0], 3);
    tick();
    check("single_grant_free", bus.grant, 0);
    check("single_busy", bus.busy, 0);

    do_reset();
    tx_rand = 1'b1;
    for (int r = 0; r < N; r++)
      for (int p = 0; p < 2; p++) begin
        push(r, 8'($urandom), 0);
        push(r, 8'($urandom), 1);
      end
    drive();
    build_expected();
    run_stream("rr", 800);

    do_reset();
    for (int r = 0; r < N; r++) begin
      int npk = $urandom_range(3, 0);
      for (int p = 0; p < npk; p++) begin
        int len = $urandom_range(4, 1);
        for (int j = 0; j < len; j++) push(r, 8'($urandom), j == len - 1);
      end
    end
    drive();
    build_expected();
    run_stream("rand", 2500);
    check("rand_no_abort", abort_cnt, 0);

    do_reset();
    tx_rand = 1'b0;
    acc = 1;
    rdy = 1;
    push(1, 8'hA1, 0);
    push(1, 8'hA2, 0);
    push(1, 8'hA3, 1);
    drive();
    wait_obs(1, 50);
    push(0, 8'hB0, 1);
    drive();
    wait_obs(3, 100);
    for (int k = 0; k < 3; k++) check($sformatf("lock_grant%0d", k), obs_gnt[k], 3'b010);
    check("lock_data2", obs_data[2], 8'hA3);
    tick();
    check("lock_grant_free", bus.grant, 0);
    tick();
    check("lock_grant_next", bus.grant, 3'b001);
    wait_obs(4, 50);
    check("lock_data3", obs_data[3], 8'hB0);
    check("lock_grant3", obs_gnt[3], 3'b001);

    do_reset();
    push(2, 8'hC5, 0);
    drive();
    wait_obs(1, 50);
    g = 0;
    while (bus.tx_valid && g < 20) begin
      tick();
      g++;
    end
    check("tmo_acked", bus.tx_valid, 0);
    push(0, 8'h33, 1);
    drive();
    for (int k = 0; k < 7; k++) tick();
    check("tmo_abort_early", bus.abort, 0);
    check("tmo_grant_held", bus.grant, 3'b100);
    tick();
    check("tmo_abort", bus.abort, 3'b100);
    check("tmo_grant_clear", bus.grant, 0);
    tick();
    check("tmo_abort_pulse", bus.abort, 0);
    check("tmo_regrant", bus.grant, 3'b001);
    wait_obs(2, 50);
    check("tmo_first_grant", obs_gnt[0], 3'b100);
    check("tmo_next_data", obs_data[1], 8'h33);
    check("tmo_next_grant", obs_gnt[1], 3'b001);
    check("tmo_no_more_from_2", rr_cnt[2], 1);

    do_reset();
    tx_auto = 1'b0;
    for (int r = 0; r < N; r++) push(r, 8'h60 + 8'(r), 1);
    drive();
    g = 0;
    while (bus.tx_valid !== 1'b1 && g < 20) begin
      tick();
      g++;
    end
    check("mid_tx_valid", bus.tx_valid, 1);
    check("mid_owner", bus.grant, 3'b001);
    tick();
    boot_reset = 1'b1;
    tick();
    check("mid_rst_tx_valid", bus.tx_valid, 0);
    check("mid_rst_grant", bus.grant, 0);
    check("mid_rst_req_ready", bus.req_ready, 0);
    check("mid_rst_busy", bus.busy, 0);
    push(0, 8'h70, 1);
    boot_reset = 1'b0;
    drive();
    tick();
    check("mid_rst_winner", bus.grant, 3'b001);

    do_reset();
    bus.tx_ready = 1'b0;
    push(0, 8'h5A, 1);
    drive();
    saw_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      saw_valid |= bus.tx_valid;
    end
    check("blk_captured", rr_cnt[0], 1);
    check("blk_tx_data", bus.tx_data, 8'h5A);
    check("blk_no_valid", saw_valid, 0);
    check("blk_no_abort", abort_cnt, 0);
    bus.tx_ready = 1'b1;
    tick();
    check("blk_release", bus.tx_valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1);
  end
endmodule
